xuart_tx: RTL and testbench
===========================

Name: xuart_tx

Overview:
- Memory-mapped UART transmitter on the external peripheral port of the picoVersat address decoder.
- Consumes the decoder's external-slot select, which drives this block's `sel` input.
- Returns read data to the decoder's external read-data input.
- The CPU writes bytes into a small TX FIFO. A bit-timing FSM serialises each byte as 8N1 on `txd`, at a programmable clock divisor.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO. Must be a power of 2, at least 2.
- DIV_W, 16, width of the baud divisor register.
- DIV_RST, 16'd434, divisor value loaded at reset (115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sel  in  1  peripheral select from the decoder, qualifies every access
- we  in  1  write enable. Write when sel=1 and we=1; read when sel=1 and we=0.
- addr  in  2  register offset within the peripheral
- data_in  in  32  write data from the CPU
- data_out  out  32  read data to the decoder
- txd  out  1  serial output, idles high
- irq  out  1  level interrupt, asserted while the FIFO is empty and the transmitter is idle

Behaviour:
- Reset (async, active-high):
  - txd=1, irq=1.
  - FIFO empty: pointers=0, count=0.
  - divisor=DIV_RST, overflow=0, FSM=IDLE, bit counter=0, baud counter=0.
- Register map (all writes take effect on the rising clk edge with sel & we):
  - offset 0 (TXDATA, W): data_in[7:0] pushed into the FIFO.
    - If the FIFO is full: byte dropped, overflow flag set (sticky).
  - offset 1 (STATUS, R):
    - bit0 busy (FSM != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow
    - bits[7:4] FIFO count, saturating at 15
    - other bits 0
  - offset 2 (DIV, R/W): divisor[DIV_W-1:0]. A write of 0 is stored as 1.
  - offset 3 (CTRL, W): data_in[0]=1 clears overflow. Reads return 0.
- data_out:
  - Combinational: selected register when sel & ~we, else 0.
  - Writes have no read side effects. Reads never pop the FIFO.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty: pop head into shift register, latch divisor into the active divisor, txd=0, go to START.
    - Transition occurs on the edge after the push edge, so txd falls 1 cycle after the write.
  - START: hold txd=0 for active-divisor cycles, then go to DATA.
  - DATA: drive shift[0] and shift right each bit period, LSB first, 8 bits. Bit counter runs 0..7, then STOP.
  - STOP: txd=1 for one bit period. Then:
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise: go to IDLE.
- Timing:
  - Bit period is exactly the active divisor in clk cycles.
  - The baud counter counts 0..div-1 and resets at each bit boundary.
  - Frame length is 10 × div cycles.
- Divisor writes during a frame do not affect the frame in flight; the new value applies from the next frame.
- Simultaneous push and pop in the same cycle: count unchanged, both take effect.
- Push when full and a pop in the same cycle: push accepted, overflow not set.
- Pointers wrap modulo FIFO_DEPTH. Count has log2(FIFO_DEPTH)+1 bits.
- irq = empty & (FSM==IDLE), registered-state derived with no extra latency.
- Reset mid-frame: txd returns to 1 immediately (asynchronous) and the FIFO contents are discarded.

Decomposition:
- Register offsets (TXDATA=0, STATUS=1, DIV=2, CTRL=3), STATUS bit positions and DIV_RST go into the shared defines header alongside the address map.
- Add a new base/width entry there for this peripheral.
- One natural sub-module: xuart_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width 8.

Test Plan:
1. Reset, then read STATUS -> 0x00000004 (empty only), txd=1, irq=1. Read DIV -> 434.
2. DIV=4, write 0x55 to TXDATA at edge T -> txd low from T+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. busy=1 throughout; irq=1 again at T+41.
3. DIV=2, write 0xA1, 0x0F, 0xFF back-to-back -> three contiguous 20-cycle frames, no idle cycle between stop and next start. STATUS count decrements per pop.
4. DIV=100, write 6 bytes quickly (depth 4, one already popped) -> 5 accepted, 6th dropped, overflow=1. Write CTRL=1 -> overflow=0.
5. Write DIV=0 -> reads back 1, frame length 10 cycles. Write DIV=8 mid-frame -> current frame keeps old timing, next frame 80 cycles.
6. Assert rst mid-DATA with 2 bytes queued -> txd=1 immediately, STATUS=0x4 after release, no further frames emitted.

Source files
------------

// File: rtl/xuart_pkg.sv
// Shared definitions for the xuart_tx peripheral: its slot in the address map,
// register offsets, STATUS bit positions, reset divisor and transmitter states.
package xuart_pkg;

  // Slot on the external peripheral port of the address decoder
  localparam logic [31:0] XUART_BASE_ADDR = 32'h0000_0100;
  localparam int          XUART_ADDR_W    = 2;

  localparam logic [1:0] XUART_TXDATA = 2'd0;
  localparam logic [1:0] XUART_STATUS = 2'd1;
  localparam logic [1:0] XUART_DIV    = 2'd2;
  localparam logic [1:0] XUART_CTRL   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // 115200 baud from a 50 MHz clock
  localparam logic [15:0] XUART_DIV_RST = 16'd434;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [3:0] sat_nibble(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/xuart_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push while full is accepted
// only when a pop happens in the same cycle; pops while empty are ignored.
module xuart_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/xuart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go through a small FIFO and are
// serialised on txd by a bit-timing FSM at a programmable clock divisor.
module xuart_tx
  import xuart_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter int              DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RST   = XUART_DIV_RST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        txd,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic             txd_q, txd_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ovf_q, ovf_d;

  logic             wr_en;
  logic             rd_en;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             bit_end;
  logic             busy;
  logic [31:0]      status;
  logic             data_in_unused;

  assign wr_en     = sel & we;
  assign rd_en     = sel & ~we;
  assign fifo_push = wr_en & (addr == XUART_TXDATA);
  assign data_in_unused = ^data_in[31:DIV_W];

  xuart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (data_in[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- register file ----------------
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_en && addr == XUART_DIV) begin
      // A zero divisor would stall the bit timer, so it is promoted to 1
      div_d = (data_in[DIV_W-1:0] == '0) ? DIV_W'(1) : data_in[DIV_W-1:0];
    end
    if (wr_en && addr == XUART_CTRL && data_in[0]) ovf_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  assign busy = (state_q != TX_IDLE);

  always_comb begin
    status                           = '0;
    status[ST_BUSY]                  = busy;
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_OVF]                   = ovf_q;
    status[ST_CNT_LSB+3:ST_CNT_LSB]  = sat_nibble(32'(fifo_count));
  end

  always_comb begin
    data_out = '0;
    if (rd_en) begin
      case (addr)
        XUART_STATUS: data_out = status;
        XUART_DIV:    data_out = 32'(div_q);
        default:      data_out = '0;
      endcase
    end
  end

  // ---------------- bit-timing FSM ----------------
  assign bit_end = (baud_cnt_q == act_div_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    act_div_d  = act_div_q;
    fifo_pop   = 1'b0;

    if (state_q != TX_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;

    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rdata;
          act_div_d  = div_q;
          txd_d      = 1'b0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            // txd is registered, so the next bit is taken before the shift lands
            txd_d     = shift_q[1];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_rdata;
            act_div_d  = div_q;
            txd_d      = 1'b0;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = TX_START;
          end else begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      txd_q      <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      act_div_q  <= DIV_RST;
      div_q      <= DIV_RST;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      act_div_q  <= act_div_d;
      div_q      <= div_d;
      ovf_q      <= ovf_d;
    end
  end

  assign txd = txd_q;
  assign irq = fifo_empty & (state_q == TX_IDLE);

endmodule

// File: tb/tb_xuart_tx.sv
// Self-checking bench for xuart_tx: a frame-schedule model predicts txd, irq and
// register reads every cycle, plus directed literal checks of key timings.
module tb_xuart_tx;
  import xuart_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        txd, irq;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  xuart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16),
    .DIV_RST    (16'd434)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .txd      (txd),
    .irq      (irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a 10-bit word {1, byte, 0} shown for 10*div cycles from its start
  logic [7:0] m_q[$];
  logic       m_ovf   = 1'b0;
  int         m_div   = 434;
  bit         m_act   = 1'b0;
  int         m_start = 0;
  int         m_fdiv  = 1;
  logic [7:0] m_byte  = 8'h00;
  int         cyc     = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_div = 434;
      m_act = 1'b0;
      cyc   = 0;
    end else begin
      cyc++;
      if (m_act && (cyc - m_start) == 10 * m_fdiv) m_act = 1'b0;
      if (!m_act && m_q.size() > 0) begin
        m_act   = 1'b1;
        m_start = cyc;
        m_fdiv  = m_div;
        m_byte  = m_q.pop_front();
      end
      if (sel && we) begin
        case (addr)
          2'd0: if (m_q.size() < DEPTH) m_q.push_back(data_in[7:0]);
                else m_ovf = 1'b1;
          2'd2: m_div = (data_in[15:0] == 16'd0) ? 1 : int'(data_in[15:0]);
          2'd3: if (data_in[0]) m_ovf = 1'b0;
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_act) return 1'b1;
    k = (cyc - m_start) / m_fdiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = m_q.size();
    s = '0;
    s[0] = m_act;
    s[1] = (n == DEPTH);
    s[2] = (n == 0);
    s[3] = m_ovf;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    return s;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd1:    return exp_status();
      2'd2:    return 32'(m_div);
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("txd", {31'd0, txd}, {31'd0, exp_txd()});
      check("irq", {31'd0, irq}, {31'd0, (m_q.size() == 0) && !m_act});
      check("data_out", data_out, (sel && !we) ? exp_rd(addr) : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; data_in = $urandom;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    check(name, data_out, exp);
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts falling edges seen with irq low, starting from the current cycle
  task automatic irq_low(input int exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (irq === 1'b0 && n < 20000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] fr;
    logic       ex;
    sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd1);
    rd_chk(XUART_STATUS, 32'h0000_0004, "rst_status");
    rd_chk(XUART_DIV, 32'd434, "rst_div");

    // Single 0x55 frame at div 4, waveform pinned literally
    wr(XUART_DIV, 32'd4);
    wr(XUART_TXDATA, 32'h55);
    fr = 10'h2AA;
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      ex = (i == 0 || i == 41) ? 1'b1 : fr[(i-1)/4];
      check("f55_txd", {31'd0, txd}, {31'd0, ex});
      check("f55_irq", {31'd0, irq}, {31'd0, i == 41});
    end
    @(posedge clk); #1;

    // Back-to-back frames at div 2
    wr(XUART_DIV, 32'd2);
    wr(XUART_TXDATA, 32'hA1);
    wr(XUART_TXDATA, 32'h0F);
    wr(XUART_TXDATA, 32'hFF);
    rd_chk(XUART_STATUS, 32'h0000_0021, "b2b_status");
    irq_low(58, "b2b_len");

    // Overflow at div 100
    wr(XUART_DIV, 32'd100);
    for (int i = 0; i < 6; i++) wr(XUART_TXDATA, 32'h00);
    rd_chk(XUART_STATUS, 32'h0000_004B, "ovf_status");
    wr(XUART_CTRL, 32'd1);
    rd_chk(XUART_STATUS, 32'h0000_0043, "ovf_clear");

    // Reset in the middle of the second frame's data bits
    idle(1300);
    rst = 1'b1;
    #1;
    check("async_txd", {31'd0, txd}, 32'd1);
    check("async_irq", {31'd0, irq}, 32'd1);
    idle(2);
    rst = 1'b0;
    rd_chk(XUART_STATUS, 32'h0000_0004, "post_rst_status");
    idle(50);

    // Divisor zero promotion and mid-frame divisor change
    wr(XUART_DIV, 32'd0);
    rd_chk(XUART_DIV, 32'd1, "div0_rd");
    wr(XUART_TXDATA, 32'h3C);
    irq_low(11, "div1_len");
    wr(XUART_TXDATA, 32'h81);
    wr(XUART_TXDATA, 32'h7E);
    idle(2);
    wr(XUART_DIV, 32'd8);
    irq_low(87, "divchg_len");

    // Randomised traffic checked by the per-cycle compare
    wr(XUART_DIV, 32'd3);
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wr(XUART_TXDATA, $urandom);
        5:             wr(XUART_DIV, 32'($urandom_range(0, 5)));
        6:             rd_chk(XUART_STATUS, exp_status(), "rnd_status");
        7: begin
          sel = 1'b1; we = 1'b0; addr = 2'($urandom_range(0, 3));
          idle(1);
          sel = 1'b0;
        end
        8:             wr(XUART_CTRL, 32'($urandom_range(0, 1)));
        default:       idle($urandom_range(0, 30));
      endcase
    end

    // Drain with a bounded wait
    for (int n = 0; n < 20000 && irq !== 1'b1; n++) @(negedge clk);
    check("drain_irq", {31'd0, irq}, 32'd1);
    rd_chk(XUART_STATUS, {24'd0, 4'd0, m_ovf, 3'b100}, "drain_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
